// File: rtl/dmaster_stream_arbiter.sv
// dmaster_stream_arbiter
//   Round-robin arbiter that shares one 8-bit Avalon-ST byte-stream sink among
//   NUM_IN byte-stream sources. It has a single registered output stage with
//   full backpressure on every source.
//
//   Optional feature macro: DMASTER_ARB_PKT_LOCK_EN
//     When defined, an IDLE/LOCKED FSM holds the grant from a start-of-packet
//     beat through the matching end-of-packet beat, and sop/eop are forwarded
//     to the sink. When undefined, every beat is arbitrated independently and
//     out_sop/out_eop are held at 0.
//
//   Ports
//     clk          rising-edge clock
//     reset_n      asynchronous active-low reset
//     in_valid     per-source beat valid             [NUM_IN]
//     in_data      source i on bits [8i+7:8i]         [8*NUM_IN]
//     in_sop       per-source startofpacket          [NUM_IN]
//     in_eop       per-source endofpacket            [NUM_IN]
//     in_ready     per-source ready, one-hot or zero  [NUM_IN]
//     out_valid    registered beat valid
//     out_data     registered beat data               [8]
//     out_sop      registered startofpacket
//     out_eop      registered endofpacket
//     out_channel  source index of the held beat      [CH_W]
//     out_ready    sink ready, readyLatency 0
module dmaster_stream_arbiter #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned CH_W   = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_IN-1:0]   in_valid,
  input  logic [8*NUM_IN-1:0] in_data,
  input  logic [NUM_IN-1:0]   in_sop,
  input  logic [NUM_IN-1:0]   in_eop,
  output logic [NUM_IN-1:0]   in_ready,
  output logic                out_valid,
  output logic [7:0]          out_data,
  output logic                out_sop,
  output logic                out_eop,
  output logic [CH_W-1:0]     out_channel,
  input  logic                out_ready
);

  localparam int unsigned DATA_W = 8;

  // Returns {found, index}: the first requester at or after 'start', wrapping.
  function automatic logic [CH_W:0] rr_search(input logic [NUM_IN-1:0] req,
                                               input logic [CH_W-1:0]   start);
    logic [CH_W:0] res;
    int unsigned   idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = 32'(start) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!res[CH_W] && req[CH_W'(idx)]) res = {1'b1, CH_W'(idx)};
    end
    return res;
  endfunction

  // Index after i, wrapping at NUM_IN.
  function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] i);
    return (i == CH_W'(NUM_IN - 1)) ? '0 : i + 1'b1;
  endfunction

  logic [DATA_W-1:0] src_data [NUM_IN];
  logic              free_c;
  logic [CH_W:0]     pick_c;
  logic [NUM_IN-1:0] grant_c;
  logic [CH_W-1:0]   gidx_c;
  logic              xfer_c;
  logic              lock_active_c;
  logic [CH_W-1:0]   lock_idx_c;
  logic              sop_c;
  logic              eop_c;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ptr_d;

  // Split the flat data bus into per-source bytes.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_src
    assign src_data[i] = in_data[DATA_W*i +: DATA_W];
  end

  // Output stage can accept a beat; held off during reset so in_ready stays 0.
  assign free_c = reset_n && (!out_valid || out_ready);
  assign pick_c = rr_search(in_valid, ptr_q);

  // Grant selection: the locked source alone, otherwise round-robin over valid sources.
  always_comb begin
    grant_c = '0;
    gidx_c  = '0;
    xfer_c  = 1'b0;
    if (lock_active_c) begin
      gidx_c              = lock_idx_c;
      grant_c[lock_idx_c] = 1'b1;
      xfer_c              = free_c && in_valid[lock_idx_c];
    end else if (pick_c[CH_W]) begin
      gidx_c          = pick_c[CH_W-1:0];
      grant_c[gidx_c] = 1'b1;
      xfer_c          = free_c;
    end
  end

  assign in_ready = free_c ? grant_c : '0;

`ifdef DMASTER_ARB_PKT_LOCK_EN

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [CH_W-1:0] lock_q;
  logic [CH_W-1:0] lock_d;

  assign lock_active_c = (state_q == ST_LOCKED);
  assign lock_idx_c    = lock_q;
  assign sop_c         = in_sop[gidx_c];
  assign eop_c         = in_eop[gidx_c];

  // FSM, lock owner and rr pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: a multi-beat packet locks its source until its eop beat.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_c) begin
          ptr_d = next_idx(gidx_c);
          if (sop_c && !eop_c) begin
            state_d = ST_LOCKED;
            lock_d  = gidx_c;
          end
        end
      end
      ST_LOCKED: begin
        if (xfer_c && eop_c) begin
          state_d = ST_IDLE;
          ptr_d   = next_idx(lock_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`else

  logic unused_ok;

  assign lock_active_c = 1'b0;
  assign lock_idx_c    = '0;
  assign sop_c         = 1'b0;
  assign eop_c         = 1'b0;
  assign unused_ok     = ^{in_sop, in_eop};

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Pointer moves past the source just served.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_c) ptr_d = next_idx(gidx_c);
  end

`endif

  // Output register: load on transfer, drop valid when drained with nothing new.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_channel <= '0;
    end else if (xfer_c) begin
      out_valid   <= 1'b1;
      out_data    <= src_data[gidx_c];
      out_sop     <= sop_c;
      out_eop     <= eop_c;
      out_channel <= gidx_c;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmaster_stream_arbiter.sv
// tb_dmaster_stream_arbiter
//   Directed scenarios followed by random traffic, checked against a cycle
//   model of the arbiter's rules (rotating priority, lock/unlock on packet
//   boundaries, one output register). Works in either build of the
//   DMASTER_ARB_PKT_LOCK_EN option.
module tb_dmaster_stream_arbiter;

  localparam int N  = 3;
  localparam int CW = 2;

`ifdef DMASTER_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   in_valid;
  logic [8*N-1:0] in_data;
  logic [N-1:0]   in_sop;
  logic [N-1:0]   in_eop;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [7:0]     out_data;
  logic           out_sop;
  logic           out_eop;
  logic [CW-1:0]  out_channel;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_ptr;
  int         m_lock;
  bit         m_locked;
  bit         m_ov;
  logic [7:0] m_od;
  int         m_och;
  bit         m_osop;
  bit         m_oeop;

  logic [N-1:0] rdy_seen;

  dmaster_stream_arbiter #(.NUM_IN(N), .CH_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_channel(out_channel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_lock = 0; m_locked = 0;
    m_ov = 0; m_od = 8'h00; m_och = 0; m_osop = 0; m_oeop = 0;
  endfunction

  // Source that would be served this cycle, or -1.
  function automatic int m_pick(input logic [N-1:0] v);
    if (m_locked) return m_lock;
    for (int k = 0; k < N; k++) begin
      if (((v >> ((m_ptr + k) % N)) & 1) != 0) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: inputs already applied at the preceding negedge.
  task automatic cycle();
    int           g;
    bit           free;
    bit           xfer;
    logic [N-1:0] er;
    logic [CW-1:0] gi;
    #1;
    g    = m_pick(in_valid);
    free = !m_ov || out_ready;
    er   = '0;
    gi   = '0;
    xfer = 1'b0;
    if (g >= 0) begin
      gi   = CW'(g);
      if (free) er = N'(1) << g;
      xfer = free && in_valid[gi];
    end
    rdy_seen = in_ready;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (xfer) begin
      m_ov   = 1'b1;
      m_od   = in_data[8*g +: 8];
      m_och  = g;
      m_osop = LOCK && in_sop[gi];
      m_oeop = LOCK && in_eop[gi];
      if (!m_locked) begin
        m_ptr = (g + 1) % N;
        if (LOCK && in_sop[gi] && !in_eop[gi]) begin
          m_locked = 1'b1;
          m_lock   = g;
        end
      end else if (in_eop[gi]) begin
        m_locked = 1'b0;
        m_ptr    = (m_lock + 1) % N;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
    chk("out_valid",   32'(out_valid),   32'(m_ov));
    chk("out_data",    32'(out_data),    32'(m_od));
    chk("out_channel", 32'(out_channel), 32'(m_och));
    chk("out_sop",     32'(out_sop),     32'(m_osop));
    chk("out_eop",     32'(out_eop),     32'(m_oeop));
  endtask

  // Reset with the given valid pattern applied; checks reset values.
  task automatic do_reset(input logic [N-1:0] v);
    in_valid  = v;
    in_sop    = '0;
    in_eop    = '0;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",    32'(in_ready),    32'd0);
    chk("rst_out_valid",   32'(out_valid),   32'd0);
    chk("rst_out_channel", 32'(out_channel), 32'd0);
    chk("rst_out_data",    32'(out_data),    32'd0);
    chk("rst_out_sop",     32'(out_sop),     32'd0);
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_data  = '0;

    // Reset with every source valid, then first beat comes from source 0.
    in_data = {8'h33, 8'h22, 8'h11};
    do_reset(3'b111);
    cycle();
    chk("t1_first_data", 32'(out_data), 32'h11);
    chk("t1_first_ch",   32'(out_channel), 32'd0);

    // Two sources alternate at full rate.
    do_reset(3'b011);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_data",  32'(out_data),  (i % 2 == 0) ? 32'h11 : 32'h22);
      chk("t2_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure holds the beat stable with no source ready.
    in_data = {8'h33, 8'h5A, 8'hA5};
    cycle();
    chk("t3_load", 32'(out_data), 32'hA5);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_hold_data",  32'(out_data),  32'hA5);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_ready", 32'(rdy_seen),  32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("t3_next", 32'(out_data), 32'h5A);
    cycle();
    chk("t3_after", 32'(out_data), 32'hA5);

`ifdef DMASTER_ARB_PKT_LOCK_EN
    // Four-beat packet from source 0 is not interleaved with source 1.
    do_reset(3'b000);
    for (int i = 0; i < 4; i++) begin
      in_valid = 3'b011;
      in_data  = {8'h00, 8'hF0, 8'(i + 1)};
      in_sop   = {1'b0, 1'b1, (i == 0)};
      in_eop   = {1'b0, 1'b1, (i == 3)};
      cycle();
      chk("t4_pkt_data", 32'(out_data),    32'(i + 1));
      chk("t4_pkt_ch",   32'(out_channel), 32'd0);
      chk("t4_pkt_sop",  32'(out_sop),     32'(i == 0));
    end
    in_valid = 3'b010;
    cycle();
    chk("t4_s1_data", 32'(out_data),    32'hF0);
    chk("t4_s1_ch",   32'(out_channel), 32'd1);

    // Locked source pauses mid-packet; source 1 must wait.
    do_reset(3'b000);
    in_valid = 3'b011;
    in_data  = {8'h00, 8'hF0, 8'h21};
    in_sop   = 3'b011;
    in_eop   = 3'b010;
    cycle();
    chk("t5_first", 32'(out_data), 32'h21);
    in_valid = 3'b010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_stall_rdy1",  32'(rdy_seen[1]), 32'd0);
      chk("t5_stall_valid", 32'(out_valid),   32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 3'b011;
      in_data  = {8'h00, 8'hF0, 8'(8'h22 + i)};
      in_sop   = 3'b010;
      in_eop   = {1'b0, 1'b1, (i == 1)};
      cycle();
      chk("t5_tail_data", 32'(out_data),    32'(8'h22 + i));
      chk("t5_tail_ch",   32'(out_channel), 32'd0);
    end
    in_valid = 3'b010;
    cycle();
    chk("t5_s1_ch", 32'(out_channel), 32'd1);

    // Reset mid-packet discards the lock.
    do_reset(3'b000);
    in_valid = 3'b001;
    in_data  = {8'h00, 8'h41, 8'h31};
    in_sop   = 3'b001;
    in_eop   = 3'b000;
    cycle();
    in_sop   = 3'b000;
    in_data  = {8'h00, 8'h41, 8'h32};
    cycle();
    do_reset(3'b000);
    in_valid = 3'b010;
    in_sop   = 3'b010;
    in_eop   = 3'b000;
    cycle();
    chk("t6_ch",   32'(out_channel), 32'd1);
    chk("t6_data", 32'(out_data),    32'h41);
`else
    // Without packet lock, sop/eop never reach the sink and beats alternate.
    do_reset(3'b000);
    in_valid = 3'b011;
    in_data  = {8'h00, 8'h62, 8'h61};
    in_sop   = 3'b011;
    in_eop   = 3'b001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("nl_ch",  32'(out_channel), 32'(i % 2));
      chk("nl_sop", 32'(out_sop),     32'd0);
      chk("nl_eop", 32'(out_eop),     32'd0);
    end
`endif

    // Random traffic against the model.
    do_reset(N'($urandom));
    for (int i = 0; i < 600; i++) begin
      in_valid  = N'($urandom);
      in_data   = (8*N)'($urandom);
      in_sop    = N'($urandom);
      in_eop    = N'($urandom) & N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
